// File: rtl/key_ctrl_if.sv
// Stopwatch key-controller bundle: raw key inputs plus the control levels and debug
// pulses fed to Time_Counter. The slave modport is the controller side.
interface key_ctrl_if;
    logic       key_start;
    logic       key_clr;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       start_evt;
    logic       clr_evt;

    modport master (
        output key_start,
        output key_clr,
        input  cnt_en,
        input  cnt_clr,
        input  state,
        input  start_evt,
        input  clr_evt
    );

    modport slave (
        input  key_start,
        input  key_clr,
        output cnt_en,
        output cnt_clr,
        output state,
        output start_evt,
        output clr_evt
    );
endinterface

// File: rtl/key_ctrl.sv
// Stopwatch key conditioning (sync + debounce + press detect) and start/stop/clear FSM.
// All outputs are registered levels so the slow counter domain can sample them directly.
module key_ctrl #(
    parameter int unsigned DEB_CNT    = 20000,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input logic       clk,
    input logic       reset,
    key_ctrl_if.slave bus
);

    localparam int unsigned     CntW   = $clog2(DEB_CNT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CNT - 1);
    localparam logic [1:0]      KeyIdle = {2{~KEY_ACTIVE}};

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    // Bit 0 is the start key, bit 1 the clear key.
    logic [1:0]      key_raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d;
    logic [1:0]      prev_q;
    logic [1:0]      evt_q, evt_d;
    logic [CntW-1:0] deb_q [2];
    logic [CntW-1:0] deb_d [2];

    state_e state_q, state_d;
    logic   cnt_en_q, cnt_clr_q;

    assign key_raw = {bus.key_clr, bus.key_start};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            deb_d[i]    = '0;
            // Any cycle where sync agrees with stable restarts the qualification window.
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + CntW'(1);
                end
            end
            // prev_q lags stable_q by one clock, so the pulse lands the cycle after acceptance.
            evt_d[i] = (stable_q[i] == KEY_ACTIVE) && (prev_q[i] != KEY_ACTIVE);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (evt_q[0]) state_d = StRun;
            end
            StRun: begin
                if (evt_q[0]) state_d = StPause;
            end
            StPause: begin
                // Clear takes priority over resume when both arrive together.
                if (evt_q[1]) begin
                    state_d = StIdle;
                end else if (evt_q[0]) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= KeyIdle;
            sync2_q   <= KeyIdle;
            stable_q  <= KeyIdle;
            prev_q    <= KeyIdle;
            evt_q     <= '0;
            deb_q[0]  <= '0;
            deb_q[1]  <= '0;
            state_q   <= StIdle;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b1;
        end else begin
            sync1_q   <= key_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            prev_q    <= stable_q;
            evt_q     <= evt_d;
            deb_q[0]  <= deb_d[0];
            deb_q[1]  <= deb_d[1];
            state_q   <= state_d;
            cnt_en_q  <= (state_d == StRun);
            cnt_clr_q <= (state_d == StIdle);
        end
    end

    assign bus.cnt_en    = cnt_en_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.state     = state_q;
    assign bus.start_evt = evt_q[0];
    assign bus.clr_evt   = evt_q[1];

endmodule
